// File: rtl/csa_resolve_178.sv
// Chunked carry-propagate resolver for the carry-save output of the 89x178 CSA tree.
// Optional operand skid buffer enabled by defining CSA_RESOLVE_SKID_EN.
module csa_resolve_178 #(
   parameter int WIDTH = 178,
   parameter int CHUNK = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_b0,
   input  logic [WIDTH-1:0] in_b1,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_carry
);

   localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
   localparam int CW     = (CHUNK < WIDTH) ? CHUNK : WIDTH;
   localparam int LAST_W = WIDTH - (NCHUNK - 1) * CHUNK;
   localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a0_q, a1_q;
   logic [CNT_W-1:0] cnt_q;
   logic             carry_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;

   logic             load_in, load_skid, skid_wr, step;
   logic [31:0]      off;
   logic [CW:0]      csum;
   logic             is_last, cout;
   logic [WIDTH-1:0] sum_merge;

   // Shifted-out bits above WIDTH are zero, so a partial last chunk adds only its valid bits.
   function automatic logic [CW:0] chunk_add(input logic [WIDTH-1:0] a0,
                                             input logic [WIDTH-1:0] a1,
                                             input logic cin,
                                             input logic [31:0] sh);
      return {1'b0, CW'(a0 >> sh)} + {1'b0, CW'(a1 >> sh)} + (CW+1)'(cin);
   endfunction

   assign off       = 32'(cnt_q) * 32'(CHUNK);
   assign csum      = chunk_add(a0_q, a1_q, carry_q, off);
   assign is_last   = (cnt_q == CNT_W'(NCHUNK - 1));
   assign cout      = is_last ? csum[LAST_W] : csum[CW];
   assign sum_merge = (sum_q & ~(WIDTH'({CW{1'b1}}) << off)) | (WIDTH'(csum[CW-1:0]) << off);

   assign out_sum   = sum_q;
   assign out_carry = cout_q;

`ifdef CSA_RESOLVE_SKID_EN
   logic             skid_vld_q;
   logic [WIDTH-1:0] skid_b0_q, skid_b1_q;
`else
   logic             skid_vld_q;
   assign skid_vld_q = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      load_in   = 1'b0;
      load_skid = 1'b0;
      skid_wr   = 1'b0;
      step      = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               load_in = 1'b1;
               state_d = ADD;
            end
         end
         ADD: begin
            step = 1'b1;
`ifdef CSA_RESOLVE_SKID_EN
            in_ready = !skid_vld_q;
            skid_wr  = in_valid && !skid_vld_q;
`endif
            if (is_last) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
`ifdef CSA_RESOLVE_SKID_EN
            in_ready = !skid_vld_q;
            if (out_ready) begin
               if (skid_vld_q) begin
                  load_skid = 1'b1;
                  state_d   = ADD;
               end else if (in_valid) begin
                  // Skid is empty and the slot frees this cycle: start the new pair directly.
                  load_in = 1'b1;
                  state_d = ADD;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               skid_wr = in_valid && !skid_vld_q;
            end
`else
            if (out_ready) state_d = IDLE;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a0_q    <= '0;
         a1_q    <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else if (load_in) begin
         a0_q    <= in_b0;
         a1_q    <= in_b1;
         cnt_q   <= '0;
         carry_q <= 1'b0;
`ifdef CSA_RESOLVE_SKID_EN
      end else if (load_skid) begin
         a0_q    <= skid_b0_q;
         a1_q    <= skid_b1_q;
         cnt_q   <= '0;
         carry_q <= 1'b0;
`endif
      end else if (step) begin
         sum_q   <= sum_merge;
         carry_q <= cout;
         cnt_q   <= cnt_q + 1'b1;
         if (is_last) cout_q <= cout;
      end
   end

`ifdef CSA_RESOLVE_SKID_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skid_vld_q <= 1'b0;
         skid_b0_q  <= '0;
         skid_b1_q  <= '0;
      end else if (skid_wr) begin
         skid_vld_q <= 1'b1;
         skid_b0_q  <= in_b0;
         skid_b1_q  <= in_b1;
      end else if (load_skid) begin
         skid_vld_q <= 1'b0;
      end
   end
`else
   logic unused_ctl;
   assign unused_ctl = load_skid ^ skid_wr ^ skid_vld_q;
`endif

endmodule

// File: tb/tb_csa_resolve_178.sv
// Scoreboard bench for csa_resolve_178; expectations come from a full-width reference add.
module tb_csa_resolve_178;

   localparam int WIDTH  = 178;
   localparam int NCHUNK = 6;
`ifdef CSA_RESOLVE_SKID_EN
   localparam int  SPACING    = NCHUNK + 1;
   localparam logic BUSY_READY = 1'b1;
`else
   localparam int  SPACING    = NCHUNK + 2;
   localparam logic BUSY_READY = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_b0 = '0;
   logic [WIDTH-1:0] in_b1 = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] out_sum;
   logic             out_carry;

   csa_resolve_178 dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_b0(in_b0), .in_b1(in_b1),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_carry(out_carry)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [WIDTH:0] exp_q[$];
   int n_vec = 0;
   int n_err = 0;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   function automatic logic [WIDTH-1:0] rnd178();
      logic [WIDTH-1:0] v = '0;
      for (int i = 0; i < 6; i++) v = (v << 32) | WIDTH'($urandom);
      return v;
   endfunction

   // Presents a pair at a negedge and holds it until accepted; returns at the negedge after acceptance.
   task automatic drive_pair(input logic [WIDTH-1:0] b0, input logic [WIDTH-1:0] b1,
                             output int acc, output bit ok);
      ok = 1'b0;
      acc = 0;
      in_b0 = b0;
      in_b1 = b1;
      in_valid = 1'b1;
      exp_q.push_back({1'b0, b0} + {1'b0, b1});
      for (int i = 0; i < 40; i++) begin
         if (in_ready) begin
            ok = 1'b1;
            @(negedge clk);
            acc = cyc;
            break;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      if (!ok) void'(exp_q.pop_back());
   endtask

   task automatic wait_valid(input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         if (out_valid) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      out_ready = 1'b0;
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      n_vec++; if (out_sum !== '0) begin n_err++; $display("FAIL reset_out_sum: got %h want 0", out_sum); end
      n_vec++; if (out_carry !== 1'b0) begin n_err++; $display("FAIL reset_out_carry: got %b want 0", out_carry); end
      rst_n = 1'b1;
      @(negedge clk);
      n_vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_err++; $display("FAIL post_reset_idle: got ready=%b valid=%b want ready=1 valid=0", in_ready, out_valid);
      end
   endtask

   task automatic test_arith();
      logic [WIDTH-1:0] t0[6];
      logic [WIDTH-1:0] t1[6];
      logic [WIDTH:0]   e;
      int  acc;
      bit  ok;
      t0[0] = WIDTH'(5);            t1[0] = WIDTH'(7);
      t0[1] = WIDTH'(32'hFFFF_FFFF); t1[1] = WIDTH'(1);
      t0[2] = '1;                   t1[2] = WIDTH'(1);
      t0[3] = '1;                   t1[3] = '1;
      t0[4] = rnd178();             t1[4] = rnd178();
      t0[5] = rnd178();             t1[5] = rnd178();
      out_ready = 1'b0;
      for (int k = 0; k < 6; k++) begin
         drive_pair(t0[k], t1[k], acc, ok);
         n_vec++; if (!ok) begin n_err++; $display("FAIL arith%0d_accept: got no handshake want handshake", k); continue; end
         n_vec++; if (in_ready !== BUSY_READY) begin
            n_err++; $display("FAIL arith%0d_busy_ready: got %b want %b", k, in_ready, BUSY_READY);
         end
         wait_valid(30, ok);
         n_vec++; if (!ok) begin n_err++; $display("FAIL arith%0d_timeout: got no out_valid want out_valid", k); continue; end
         n_vec++; if (cyc - acc != NCHUNK) begin
            n_err++; $display("FAIL arith%0d_latency: got %0d want %0d", k, cyc - acc, NCHUNK);
         end
         e = exp_q.pop_front();
         n_vec++; if ({out_carry, out_sum} !== e) begin
            n_err++; $display("FAIL arith%0d_result: got %b_%h want %b_%h", k, out_carry, out_sum, e[WIDTH], e[WIDTH-1:0]);
         end
         n_vec++; if (in_ready !== BUSY_READY) begin
            n_err++; $display("FAIL arith%0d_done_ready: got %b want %b", k, in_ready, BUSY_READY);
         end
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
         n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL arith%0d_release: got valid=%b ready=%b want valid=0 ready=1", k, out_valid, in_ready);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [WIDTH:0] e;
      int  acc;
      bit  ok;
      out_ready = 1'b0;
      drive_pair(rnd178(), rnd178(), acc, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL bp_accept: got no handshake want handshake"); return; end
      wait_valid(30, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL bp_timeout: got no out_valid want out_valid"); return; end
      e = exp_q.pop_front();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_vec++; if (out_valid !== 1'b1 || {out_carry, out_sum} !== e) begin
            n_err++; $display("FAIL bp_hold%0d: got valid=%b %b_%h want valid=1 %b_%h",
                              i, out_valid, out_carry, out_sum, e[WIDTH], e[WIDTH-1:0]);
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_err++; $display("FAIL bp_release: got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset_mid_add();
      logic [WIDTH:0] e;
      int  acc;
      bit  ok;
      out_ready = 1'b0;
      drive_pair(WIDTH'(9), WIDTH'(9), acc, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL rst_mid_accept: got no handshake want handshake"); return; end
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      void'(exp_q.pop_back());
      n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_err++; $display("FAIL rst_mid_state: got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready);
      end
      n_vec++; if (out_sum !== '0 || out_carry !== 1'b0) begin
         n_err++; $display("FAIL rst_mid_outputs: got %b_%h want 0_0", out_carry, out_sum);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      drive_pair(WIDTH'(3), WIDTH'(4), acc, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL rst_after_accept: got no handshake want handshake"); return; end
      wait_valid(30, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL rst_after_timeout: got no out_valid want out_valid"); return; end
      n_vec++; if (cyc - acc != NCHUNK) begin
         n_err++; $display("FAIL rst_after_latency: got %0d want %0d", cyc - acc, NCHUNK);
      end
      e = exp_q.pop_front();
      n_vec++; if ({out_carry, out_sum} !== e) begin
         n_err++; $display("FAIL rst_after_result: got %b_%h want %b_%h", out_carry, out_sum, e[WIDTH], e[WIDTH-1:0]);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [WIDTH-1:0] p0[4];
      logic [WIDTH-1:0] p1[4];
      int vc[4];
      p0[0] = WIDTH'(1); p1[0] = WIDTH'(1);
      p0[1] = '0;        p0[1][89] = 1'b1;
      p1[1] = p0[1];
      p0[2] = rnd178();  p1[2] = rnd178();
      p0[3] = rnd178();  p1[3] = rnd178();
      out_ready = 1'b1;
      fork
         begin
            int  acc;
            bit  ok;
            for (int k = 0; k < 4; k++) begin
               drive_pair(p0[k], p1[k], acc, ok);
               n_vec++; if (!ok) begin n_err++; $display("FAIL b2b%0d_accept: got no handshake want handshake", k); end
            end
         end
         begin
            logic [WIDTH:0] e;
            bit ok;
            for (int k = 0; k < 4; k++) begin
               wait_valid(60, ok);
               n_vec++; if (!ok) begin n_err++; $display("FAIL b2b%0d_timeout: got no out_valid want out_valid", k); break; end
               vc[k] = cyc;
               e = exp_q.pop_front();
               n_vec++; if ({out_carry, out_sum} !== e) begin
                  n_err++; $display("FAIL b2b%0d_result: got %b_%h want %b_%h", k, out_carry, out_sum, e[WIDTH], e[WIDTH-1:0]);
               end
               if (k > 0) begin
                  n_vec++; if (vc[k] - vc[k-1] != SPACING) begin
                     n_err++; $display("FAIL b2b%0d_spacing: got %0d want %0d", k, vc[k] - vc[k-1], SPACING);
                  end
               end
               @(negedge clk);
            end
         end
      join
      out_ready = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_arith();
      test_backpressure();
      test_reset_mid_add();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
